// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and constants for the memory responder
package mem_pkg;

  // Responder handshake states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int DATA_W      = 32;
  localparam int DEF_ADDR_W  = 9;
  localparam int DEF_LATENCY = 2;

  // Wide enough for the largest legal LATENCY (15)
  localparam int CNT_W = 4;

  // Even-parity bit: XOR of the whole stored word including this bit is 0
  function automatic logic even_parity(input logic [DATA_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/mem_array.sv
// rtl/mem_array.sv - synchronous single-port RAM with registered read port (width widened by top when MEM_RESPONDER_PARITY_EN)
module mem_array #(
  parameter int ADDR_W = 9,
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [2**ADDR_W];

  // Storage array; never reset so contents survive a responder reset
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // Read register doubles as the responder's data output, so it is reset to 0
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - 4-phase handshake memory responder with fixed access latency; MEM_RESPONDER_PARITY_EN adds per-word parity
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Read,
  input  logic              Write,
  input  logic [ADDR_W-1:0] Address,
  input  logic [DATA_W-1:0] DataIn,
  output logic [DATA_W-1:0] DataOut,
  output logic              MemReady,
  output logic              Busy,
  output logic              ReqErr,
  output logic              ParityErr
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(LATENCY - 1);

`ifdef MEM_RESPONDER_PARITY_EN
  localparam int WORD_W = DATA_W + 1;
`else
  localparam int WORD_W = DATA_W;
`endif

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic                op_write;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_data;

  logic                complete;
  logic                mem_we;
  logic                mem_re;
  logic [WORD_W-1:0]   mem_wdata;
  logic [WORD_W-1:0]   mem_rdata;

  // The access happens on the edge that ends the latency window; reset on
  // the same edge suppresses it so an aborted write never commits.
  assign complete = (state == ACCESS) && (cnt == LAST);
  assign mem_we   = complete && op_write && !Reset;
  assign mem_re   = complete && !op_write && !Reset;

`ifdef MEM_RESPONDER_PARITY_EN
  assign mem_wdata = {even_parity(lat_data), lat_data};
  assign DataOut   = mem_rdata[DATA_W-1:0];
  // Read register resets to all-zero, which is a consistent word, so the flag clears on reset
  assign ParityErr = ^mem_rdata;
`else
  assign mem_wdata = lat_data;
  assign DataOut   = mem_rdata;
  assign ParityErr = 1'b0;
`endif

  // Handshake FSM: accept and latch in IDLE, count in ACCESS, hold MemReady in DONE
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= IDLE;
      cnt      <= '0;
      op_write <= 1'b0;
      lat_addr <= '0;
      lat_data <= '0;
      MemReady <= 1'b0;
      Busy     <= 1'b0;
      ReqErr   <= 1'b0;
    end else begin
      ReqErr <= 1'b0;
      case (state)
        IDLE: begin
          if (Read ^ Write) begin
            lat_addr <= Address;
            lat_data <= DataIn;
            op_write <= Write;
            cnt      <= '0;
            Busy     <= 1'b1;
            state    <= ACCESS;
          end else if (Read && Write) begin
            ReqErr <= 1'b1;
          end
        end
        ACCESS: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            Busy     <= 1'b0;
            MemReady <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          if (!Read && !Write) begin
            MemReady <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  mem_array #(
    .ADDR_W(ADDR_W),
    .WORD_W(WORD_W)
  ) u_array (
    .clk  (Clock),
    .rst  (Reset),
    .we   (mem_we),
    .re   (mem_re),
    .addr (lat_addr),
    .wdata(mem_wdata),
    .rdata(mem_rdata)
  );

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - directed self-checking bench for mem_responder
module tb_mem_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd;
  logic        wr;
  logic [9:0]  mar;
  logic [31:0] din;
  wire  [8:0]  address = mar[8:0];
  logic [31:0] dout;
  logic        mem_ready;
  logic        busy;
  logic        req_err;
  logic        parity_err;

  int n_checks = 0;
  int n_fail   = 0;

  mem_responder #(
    .ADDR_W (9),
    .LATENCY(LAT)
  ) u_dut (
    .Clock    (clk),
    .Reset    (rst),
    .Read     (rd),
    .Write    (wr),
    .Address  (address),
    .DataIn   (din),
    .DataOut  (dout),
    .MemReady (mem_ready),
    .Busy     (busy),
    .ReqErr   (req_err),
    .ParityErr(parity_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One full handshake; perturb scrambles Address/DataIn right after acceptance
  task automatic do_access(input bit is_wr, input logic [9:0] a, input logic [31:0] d,
                           input bit perturb, input string tag, output logic [31:0] rdata);
    int  n;
    int  busy_n;
    bit  done;
    @(negedge clk);
    rd  = !is_wr;
    wr  = is_wr;
    mar = a;
    din = d;
    n = 0;
    busy_n = 0;
    done = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
      if (perturb && n == 1) begin
        mar = 10'h1FF;
        din = ~d;
      end
      if (busy) busy_n++;
      if (mem_ready) done = 1;
    end
    check({tag, "_ready_latency"}, 32'(n - 1), 32'(LAT));
    check({tag, "_busy_cycles"}, 32'(busy_n), 32'(LAT));
    rdata = dout;
    @(negedge clk);
    check({tag, "_ready_held"}, 32'(mem_ready), 32'd1);
    rd = 1'b0;
    wr = 1'b0;
    @(negedge clk);
    check({tag, "_ready_cleared"}, 32'(mem_ready), 32'd0);
  endtask

  logic [31:0] r;

  initial begin
    rst = 1'b1;
    rd  = 1'b0;
    wr  = 1'b0;
    mar = '0;
    din = '0;
    repeat (3) @(negedge clk);
    check("rst_dout", dout, 32'h0);
    check("rst_ready", 32'(mem_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_reqerr", 32'(req_err), 32'd0);
    check("rst_parity", 32'(parity_err), 32'd0);
    rst = 1'b0;

    do_access(1'b1, 10'h1FF, 32'h1111_1111, 1'b0, "wr_1ff", r);
    do_access(1'b1, 10'h010, 32'hDEAD_BEEF, 1'b0, "wr_010", r);
    check("wr_keeps_dout", dout, 32'h0);
    do_access(1'b0, 10'h010, 32'h0, 1'b0, "rd_010", r);
    check("rd_010_data", r, 32'hDEAD_BEEF);
    check("rd_010_parity", 32'(parity_err), 32'd0);

    // Illegal request: both strobes high for one edge
    @(negedge clk);
    rd  = 1'b1;
    wr  = 1'b1;
    mar = 10'h010;
    din = 32'h0000_0000;
    @(negedge clk);
    check("reqerr_pulse", 32'(req_err), 32'd1);
    check("reqerr_no_ready", 32'(mem_ready), 32'd0);
    check("reqerr_no_busy", 32'(busy), 32'd0);
    rd = 1'b0;
    wr = 1'b0;
    @(negedge clk);
    check("reqerr_one_cycle", 32'(req_err), 32'd0);
    do_access(1'b0, 10'h010, 32'h0, 1'b0, "rd_after_err", r);
    check("mem_unchanged_by_err", r, 32'hDEAD_BEEF);

    // Reset in the middle of a write must abort it
    do_access(1'b1, 10'h020, 32'hA5A5_0020, 1'b0, "wr_020", r);
    @(negedge clk);
    wr  = 1'b1;
    mar = 10'h020;
    din = 32'h1234_5678;
    @(negedge clk);
    check("abort_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_dout", dout, 32'h0);
    check("abort_ready", 32'(mem_ready), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_reqerr", 32'(req_err), 32'd0);
    check("abort_parity", 32'(parity_err), 32'd0);
    rst = 1'b0;
    wr  = 1'b0;
    do_access(1'b0, 10'h020, 32'h0, 1'b0, "rd_020", r);
    check("abort_no_commit", r, 32'hA5A5_0020);

    // Address and data changed mid-access are ignored
    do_access(1'b1, 10'h010, 32'hCAFE_F00D, 1'b1, "wr_perturb", r);
    do_access(1'b0, 10'h010, 32'h0, 1'b1, "rd_perturb", r);
    check("perturb_data_010", r, 32'hCAFE_F00D);
    do_access(1'b0, 10'h1FF, 32'h0, 1'b0, "rd_1ff", r);
    check("perturb_1ff_untouched", r, 32'h1111_1111);
    do_access(1'b0, 10'h210, 32'h0, 1'b0, "rd_wrap", r);
    check("wrap_210_to_010", r, 32'hCAFE_F00D);

    // Writes leave DataOut alone; back-to-back read returns new data
    do_access(1'b1, 10'h033, 32'h0BAD_F00D, 1'b0, "wr_033", r);
    check("wr_holds_dout", dout, 32'hCAFE_F00D);
    do_access(1'b0, 10'h033, 32'h0, 1'b0, "rd_033", r);
    check("raw_033", r, 32'h0BAD_F00D);

`ifdef MEM_RESPONDER_PARITY_EN
    do_access(1'b1, 10'h005, 32'h0F0F_0F0F, 1'b0, "wr_005", r);
    u_dut.u_array.mem[5] = u_dut.u_array.mem[5] ^ 33'h0_0000_0008;
    do_access(1'b0, 10'h005, 32'h0, 1'b0, "rd_005", r);
    check("parity_err_set", 32'(parity_err), 32'd1);
    do_access(1'b1, 10'h006, 32'h0000_0001, 1'b0, "wr_006", r);
    check("parity_err_held", 32'(parity_err), 32'd1);
    do_access(1'b0, 10'h033, 32'h0, 1'b0, "rd_clean", r);
    check("parity_err_clear", 32'(parity_err), 32'd0);
`else
    check("parity_tied_low", 32'(parity_err), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
